// File: rtl/store_buffer_pkg.sv
// Store buffer shared types: entry record, access size codes, size helpers.
// Interface widths default here unless the build provides them.
`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 5
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef SIZE_WIDTH
`define SIZE_WIDTH 2
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif

package store_buffer_pkg;

  localparam logic [`SIZE_WIDTH-1:0] SIZE_BYTE = `SIZE_WIDTH'(0);
  localparam logic [`SIZE_WIDTH-1:0] SIZE_HALF = `SIZE_WIDTH'(1);
  localparam logic [`SIZE_WIDTH-1:0] SIZE_WORD = `SIZE_WIDTH'(2);

  typedef struct packed {
    logic [`ROB_ID_WIDTH-1:0]   rob_id;
    logic [`ADDR_WIDTH-1:0]     addr;
    logic [`SIZE_WIDTH-1:0]     size;
    logic [`BUS_DATA_WIDTH-1:0] data;
  } stbuf_entry_t;

  function automatic logic [`BUS_DATA_WIDTH-1:0] size_mask(
    input logic [`SIZE_WIDTH-1:0]     size,
    input logic [`BUS_DATA_WIDTH-1:0] data
  );
    logic [`BUS_DATA_WIDTH-1:0] m;
    case (size)
      SIZE_BYTE: m = `BUS_DATA_WIDTH'('hFF);
      SIZE_HALF: m = `BUS_DATA_WIDTH'('hFFFF);
      default:   m = '1;
    endcase
    return data & m;
  endfunction

  // Byte length, one bit wider than an address so range ends never wrap.
  function automatic logic [`ADDR_WIDTH:0] size_bytes(
    input logic [`SIZE_WIDTH-1:0] size
  );
    logic [`ADDR_WIDTH:0] n;
    case (size)
      SIZE_BYTE: n = (`ADDR_WIDTH+1)'(1);
      SIZE_HALF: n = (`ADDR_WIDTH+1)'(2);
      default:   n = (`ADDR_WIDTH+1)'(4);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Load-vs-store compare over valid entries, youngest relevant entry wins.
// Ports: entries, head_idx, count, load_addr/size in; overlap (+hit, hit_idx when STBUF_FORWARD_EN).
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = $clog2(DEPTH) + 1
) (
  input  stbuf_entry_t [DEPTH-1:0]     entries,
  input  logic [PTR_WIDTH-2:0]         head_idx,
  input  logic [PTR_WIDTH-1:0]         count,
  input  logic [`ADDR_WIDTH-1:0]       load_addr,
  input  logic [`SIZE_WIDTH-1:0]       load_size,
`ifdef STBUF_FORWARD_EN
  output logic                         hit,
  output logic [PTR_WIDTH-2:0]         hit_idx,
`endif
  output logic                         overlap
);

  localparam int IDX_W = PTR_WIDTH - 1;

  logic [`ADDR_WIDTH:0] l_lo;
  logic [`ADDR_WIDTH:0] l_hi;

  assign l_lo = {1'b0, load_addr};
  assign l_hi = l_lo + size_bytes(load_size);

  // Walk oldest to youngest so a later assignment means a younger entry.
  always_comb begin
    overlap = 1'b0;
`ifdef STBUF_FORWARD_EN
    hit     = 1'b0;
    hit_idx = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      logic [IDX_W-1:0]     idx;
      logic [`ADDR_WIDTH:0] e_lo;
      logic [`ADDR_WIDTH:0] e_hi;
      idx  = head_idx + IDX_W'(k);
      e_lo = {1'b0, entries[idx].addr};
      e_hi = e_lo + size_bytes(entries[idx].size);
      if (PTR_WIDTH'(k) < count && e_lo < l_hi && l_lo < e_hi) begin
`ifdef STBUF_FORWARD_EN
        hit     = (entries[idx].addr == load_addr) &&
                  (entries[idx].size >= load_size);
        overlap = !hit;
        hit_idx = idx;
`else
        overlap = 1'b1;
`endif
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Ordered store buffer: speculative/committed stores, drain, load forwarding.
// Ports: LSU push/load, ROB retire/flush, bus write drain and bus read; STBUF_FORWARD_EN enables forwarding.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       exlsu_stbuf_push,
  input  logic [`ROB_ID_WIDTH-1:0]   exlsu_stbuf_rob_id,
  input  logic [`ADDR_WIDTH-1:0]     exlsu_stbuf_write_addr,
  input  logic [`SIZE_WIDTH-1:0]     exlsu_stbuf_write_size,
  input  logic [`BUS_DATA_WIDTH-1:0] exlsu_stbuf_write_data,
  output logic                       stbuf_exlsu_full,
  input  logic                       exlsu_stbuf_read_req,
  input  logic [`ADDR_WIDTH-1:0]     exlsu_stbuf_read_addr,
  input  logic [`SIZE_WIDTH-1:0]     exlsu_stbuf_read_size,
  output logic [`BUS_DATA_WIDTH-1:0] stbuf_exlsu_bus_data_feedback,
  output logic                       stbuf_exlsu_bus_ready,
  input  logic                       commit_stbuf_retire,
  input  logic [`ROB_ID_WIDTH-1:0]   commit_stbuf_retire_rob_id,
  input  logic                       commit_stbuf_flush,
  output logic                       stbuf_bus_write_req,
  output logic [`ADDR_WIDTH-1:0]     stbuf_bus_write_addr,
  output logic [`SIZE_WIDTH-1:0]     stbuf_bus_write_size,
  output logic [`BUS_DATA_WIDTH-1:0] stbuf_bus_write_data,
  input  logic                       bus_stbuf_write_ack,
  output logic                       stbuf_bus_read_req,
  output logic [`ADDR_WIDTH-1:0]     stbuf_bus_read_addr,
  output logic [`SIZE_WIDTH-1:0]     stbuf_bus_read_size,
  input  logic [`BUS_DATA_WIDTH-1:0] bus_stbuf_read_data,
  input  logic                       bus_stbuf_read_ack
);

  localparam int IDX_W = PTR_WIDTH - 1;

  stbuf_entry_t [DEPTH-1:0] entries;

  logic [PTR_WIDTH-1:0] head;
  logic [PTR_WIDTH-1:0] commit;
  logic [PTR_WIDTH-1:0] tail;
  logic [PTR_WIDTH-1:0] count;
  logic [PTR_WIDTH-1:0] commit_nxt;
  logic                 full;
  logic                 push_ok;
  logic                 retire_ok;
  logic                 pop;
  logic                 overlap;
  stbuf_entry_t         head_e;

  assign count     = tail - head;
  assign full      = (count == PTR_WIDTH'(DEPTH));
  assign push_ok   = exlsu_stbuf_push && !full && !commit_stbuf_flush;
  assign retire_ok = commit_stbuf_retire && (commit != tail) &&
                     (entries[commit[IDX_W-1:0]].rob_id ==
                      commit_stbuf_retire_rob_id);
  assign commit_nxt = commit + PTR_WIDTH'(retire_ok);
  assign pop        = stbuf_bus_write_req && bus_stbuf_write_ack;
  assign head_e     = entries[head[IDX_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head   <= '0;
      commit <= '0;
      tail   <= '0;
    end else begin
      head   <= head + PTR_WIDTH'(pop);
      commit <= commit_nxt;
      // Flush discards everything younger than the committed prefix.
      tail   <= commit_stbuf_flush ? commit_nxt
                                   : tail + PTR_WIDTH'(push_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      entries[tail[IDX_W-1:0]] <= '{
        rob_id: exlsu_stbuf_rob_id,
        addr:   exlsu_stbuf_write_addr,
        size:   exlsu_stbuf_write_size,
        data:   exlsu_stbuf_write_data
      };
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && commit_stbuf_retire) begin
      assert (retire_ok)
        else $error("store_buffer: retire id mismatch or nothing to retire");
    end
  end
`endif

  assign stbuf_exlsu_full     = full;
  assign stbuf_bus_write_req  = (head != commit);
  assign stbuf_bus_write_addr = stbuf_bus_write_req ? head_e.addr : '0;
  assign stbuf_bus_write_size = stbuf_bus_write_req ? head_e.size : '0;
  assign stbuf_bus_write_data = stbuf_bus_write_req ? head_e.data : '0;

`ifdef STBUF_FORWARD_EN
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
`endif

  store_buffer_match #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_match (
    .entries   (entries),
    .head_idx  (head[IDX_W-1:0]),
    .count     (count),
    .load_addr (exlsu_stbuf_read_addr),
    .load_size (exlsu_stbuf_read_size),
`ifdef STBUF_FORWARD_EN
    .hit       (hit),
    .hit_idx   (hit_idx),
`endif
    .overlap   (overlap)
  );

  always_comb begin
    stbuf_bus_read_req            = 1'b0;
    stbuf_exlsu_bus_ready         = 1'b0;
    stbuf_exlsu_bus_data_feedback = '0;
    if (!rst && exlsu_stbuf_read_req) begin
`ifdef STBUF_FORWARD_EN
      if (hit) begin
        stbuf_exlsu_bus_ready         = 1'b1;
        stbuf_exlsu_bus_data_feedback =
          size_mask(exlsu_stbuf_read_size, entries[hit_idx].data);
      end else
`endif
      if (!overlap) begin
        stbuf_bus_read_req    = 1'b1;
        stbuf_exlsu_bus_ready = bus_stbuf_read_ack;
        if (bus_stbuf_read_ack)
          stbuf_exlsu_bus_data_feedback =
            size_mask(exlsu_stbuf_read_size, bus_stbuf_read_data);
      end
    end
  end

  assign stbuf_bus_read_addr = stbuf_bus_read_req ? exlsu_stbuf_read_addr : '0;
  assign stbuf_bus_read_size = stbuf_bus_read_req ? exlsu_stbuf_read_size : '0;

endmodule
